assembler: RTL and testbench

ASSEMBLER -- requirements
Module: assembler

---
 rtl/assembler.sv | 124 ++++++++++++
 tb/tb_assembler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/assembler.sv
// Packet assembler: prepends a header to a stream of 32-bit float lane beats and emits AXI-Stream phits.
// Define ASSEMBLER_HDR_SWAP_EN to swap the two 32-bit header halves on emission (reply to source).
module assembler #(
  parameter int phit_size    = 512,
  parameter int header_bytes = 8,
  parameter int SIMD_degree  = phit_size / 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [header_bytes*8-1:0] hdr_data_in,
  input  logic                      hdr_valid_in,
  output logic                      hdr_ready_out,
  input  logic [phit_size-1:0]      lane_data_in,
  input  logic [SIMD_degree-1:0]    lane_valid_in,
  input  logic [SIMD_degree-1:0]    lane_last_in,
  output logic                      lane_ready_out,
  output logic [phit_size-1:0]      tdata_out,
  output logic [phit_size/8-1:0]    tkeep_out,
  output logic                      tlast_out,
  output logic                      tvalid_out,
  input  logic                      tready_in
);

  localparam int HW = header_bytes * 8;
  localparam int KB = phit_size / 8;

  typedef enum logic [1:0] {IDLE, PAYLOAD, FLUSH} state_t;

  state_t                  state;
  logic [HW-1:0]           hdr_q;
  logic                    hdr_full;
  logic [HW-1:0]           carry;
  logic [header_bytes-1:0] carry_keep;

  logic          out_free;
  logic          lane_fire;
  logic          is_last;
  logic [KB-1:0] lane_keep;
  logic [HW-1:0] hdr_emit;

  always_comb begin
    lane_keep = '0;
    for (int i = 0; i < SIMD_degree; i++)
      lane_keep[4*i +: 4] = {4{lane_valid_in[i]}};
  end

`ifdef ASSEMBLER_HDR_SWAP_EN
  assign hdr_emit = {hdr_q[HW/2-1:0], hdr_q[HW-1:HW/2]};
`else
  assign hdr_emit = hdr_q;
`endif

  assign out_free       = !tvalid_out || tready_in;
  assign hdr_ready_out  = !hdr_full;
  assign lane_ready_out = (state != FLUSH) && out_free && ((state != IDLE) || hdr_full);
  assign is_last        = |lane_last_in;
  assign lane_fire      = lane_ready_out && ((|lane_valid_in) || is_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hdr_q      <= '0;
      hdr_full   <= 1'b0;
      carry      <= '0;
      carry_keep <= '0;
      tdata_out  <= '0;
      tkeep_out  <= '0;
      tlast_out  <= 1'b0;
      tvalid_out <= 1'b0;
    end else begin
      // a header may land at any time; it is only consumed by the first beat of a packet
      if (hdr_valid_in && hdr_ready_out) begin
        hdr_q    <= hdr_data_in;
        hdr_full <= 1'b1;
      end else if (state == IDLE && lane_fire) begin
        hdr_full <= 1'b0;
      end

      if (out_free) tvalid_out <= 1'b0;

      case (state)
        IDLE, PAYLOAD: begin
          if (lane_fire) begin
            if (state == IDLE) begin
              tdata_out <= {lane_data_in[phit_size-HW-1:0], hdr_emit};
              tkeep_out <= {lane_keep[KB-header_bytes-1:0], {header_bytes{1'b1}}};
            end else begin
              tdata_out <= {lane_data_in[phit_size-HW-1:0], carry};
              tkeep_out <= {lane_keep[KB-header_bytes-1:0], carry_keep};
            end
            tvalid_out <= 1'b1;
            carry      <= lane_data_in[phit_size-1 -: HW];
            carry_keep <= lane_keep[KB-1 -: header_bytes];
            if (is_last) begin
              if (|lane_keep[KB-1 -: header_bytes]) begin
                tlast_out <= 1'b0;
                state     <= FLUSH;
              end else begin
                tlast_out <= 1'b1;
                state     <= IDLE;
              end
            end else begin
              tlast_out <= 1'b0;
              state     <= PAYLOAD;
            end
          end
        end
        FLUSH: begin
          if (out_free) begin
            tdata_out  <= {{(phit_size-HW){1'b0}}, carry};
            tkeep_out  <= {{(KB-header_bytes){1'b0}}, carry_keep};
            tlast_out  <= 1'b1;
            tvalid_out <= 1'b1;
            carry      <= '0;
            carry_keep <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_assembler.sv
// Scoreboard bench for assembler: a byte-stream model predicts output phits; a monitor pops and compares.
// Honours ASSEMBLER_HDR_SWAP_EN when predicting the emitted header.
module tb_assembler;
  localparam int PS = 512;
  localparam int HB = 8;
  localparam int NL = 16;

  logic            clk;
  logic            rst_n;
  logic [HB*8-1:0] hdr_data_in;
  logic            hdr_valid_in;
  logic            hdr_ready_out;
  logic [PS-1:0]   lane_data_in;
  logic [NL-1:0]   lane_valid_in;
  logic [NL-1:0]   lane_last_in;
  logic            lane_ready_out;
  logic [PS-1:0]   tdata_out;
  logic [PS/8-1:0] tkeep_out;
  logic            tlast_out;
  logic            tvalid_out;
  logic            tready_in;

  assembler dut (
    .clk(clk), .rst_n(rst_n),
    .hdr_data_in(hdr_data_in), .hdr_valid_in(hdr_valid_in), .hdr_ready_out(hdr_ready_out),
    .lane_data_in(lane_data_in), .lane_valid_in(lane_valid_in), .lane_last_in(lane_last_in),
    .lane_ready_out(lane_ready_out),
    .tdata_out(tdata_out), .tkeep_out(tkeep_out), .tlast_out(tlast_out), .tvalid_out(tvalid_out),
    .tready_in(tready_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [PS-1:0]   d;
    logic [PS/8-1:0] k;
    logic            l;
  } beat_t;

  beat_t  sb[$];
  int     checks = 0;
  int     errors = 0;
  logic   ignore_out = 1'b0;

  task automatic chk(input string name, input logic [PS-1:0] act, input logic [PS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lw(input int p, input int b, input int l);
    logic [7:0] pp, bb, ll;
    pp = p[7:0]; bb = b[7:0]; ll = l[7:0];
    return {pp, bb, ll, 8'h5A};
  endfunction

  function automatic logic [PS-1:0] beat_data(input int p, input int b);
    logic [PS-1:0] d;
    d = '0;
    for (int l = 0; l < NL; l++) d[32*l +: 32] = lw(p, b, l);
    return d;
  endfunction

  function automatic logic [NL-1:0] lane_mask(input int n);
    logic [NL:0] one;
    one = 1;
    return NL'((one << n) - 1);
  endfunction

  // Model: header bytes then every valid lane byte, repacked into 64-byte phits.
  task automatic push_packet(input logic [63:0] hdr, input int p, input int nbeats, input int last_lanes);
    logic [7:0] s[$];
    logic [63:0] h;
    beat_t e;
    int nb, lanes, idx;
`ifdef ASSEMBLER_HDR_SWAP_EN
    h = {hdr[31:0], hdr[63:32]};
`else
    h = hdr;
`endif
    for (int k = 0; k < HB; k++) s.push_back(h[8*k +: 8]);
    for (int b = 0; b < nbeats; b++) begin
      lanes = (b == nbeats - 1) ? last_lanes : NL;
      for (int l = 0; l < lanes; l++)
        for (int k = 0; k < 4; k++) s.push_back(lw(p, b, l) >> (8*k));
    end
    nb = (s.size() + 63) / 64;
    for (int i = 0; i < nb; i++) begin
      e = '0;
      for (int k = 0; k < 64; k++) begin
        idx = 64*i + k;
        if (idx < s.size()) begin
          e.d[8*k +: 8] = s[idx];
          e.k[k] = 1'b1;
        end
      end
      e.l = (i == nb - 1);
      sb.push_back(e);
    end
  endtask

  // Monitor: pops on each transfer and checks holding behaviour during stalls.
  initial begin : monitor
    beat_t e, held, cur;
    logic [PS-1:0] m;
    logic stalled;
    stalled = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      cur = '{d: tdata_out, k: tkeep_out, l: tlast_out};
      if (!rst_n || !tvalid_out) begin
        stalled = 1'b0;
      end else begin
        if (stalled) chk("stall_hold", PS'(cur), PS'(held));
        if (tready_in && !ignore_out) begin
          if (sb.size() == 0) begin
            chk("unexpected_beat", 1, 0);
          end else begin
            e = sb.pop_front();
            m = '0;
            for (int k = 0; k < 64; k++) m[8*k +: 8] = {8{e.k[k]}};
            chk("tdata", tdata_out & m, e.d);
            chk("tkeep", PS'(tkeep_out), PS'(e.k));
            chk("tlast", PS'(tlast_out), PS'(e.l));
          end
        end
        stalled = !tready_in;
        held = cur;
      end
    end
  end

  task automatic send_hdr(input logic [63:0] h);
    int n;
    hdr_data_in = h;
    hdr_valid_in = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!hdr_ready_out && n < 300);
    if (!hdr_ready_out) chk("hdr_timeout", 1, 0);
    @(posedge clk); #1;
    hdr_valid_in = 1'b0;
  endtask

  task automatic drive_beat(input logic [PS-1:0] d, input logic [NL-1:0] v, input logic last);
    int n;
    lane_data_in = d;
    lane_valid_in = v;
    lane_last_in = last ? 16'h8000 : 16'h0000;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lane_ready_out && n < 300);
    if (!lane_ready_out) chk("lane_timeout", 1, 0);
    @(posedge clk); #1;
    lane_valid_in = '0;
    lane_last_in = '0;
  endtask

  task automatic send_lanes(input int p, input int nbeats, input int last_lanes);
    for (int b = 0; b < nbeats; b++)
      drive_beat(beat_data(p, b), (b == nbeats - 1) ? lane_mask(last_lanes) : lane_mask(NL),
                 b == nbeats - 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", PS'(sb.size()), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    hdr_data_in = '0; hdr_valid_in = 1'b0;
    lane_data_in = '0; lane_valid_in = '0; lane_last_in = '0;
    tready_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_tvalid", PS'(tvalid_out), 0);
    chk("rst_tdata", tdata_out, 0);
    chk("rst_lane_ready", PS'(lane_ready_out), 0);
    chk("rst_hdr_ready", PS'(hdr_ready_out), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // full 16-lane last beat: spills two lanes into a flush phit
    push_packet(64'h1122334455667788, 1, 1, 16);
    send_hdr(64'h1122334455667788);
    send_lanes(1, 1, 16);
    drain();

    // 14 lanes fill the phit exactly, no flush
    push_packet(64'hA5A5_0000_1234_5678, 2, 1, 14);
    send_hdr(64'hA5A5_0000_1234_5678);
    send_lanes(2, 1, 14);
    drain();

    // header-only packet
    push_packet(64'hDEAD_BEEF_CAFE_F00D, 3, 1, 0);
    send_hdr(64'hDEAD_BEEF_CAFE_F00D);
    send_lanes(3, 1, 0);
    drain();

    // three full beats under a toggling downstream ready
    push_packet(64'h0102_0304_0506_0708, 4, 3, 16);
    send_hdr(64'h0102_0304_0506_0708);
    fork
      send_lanes(4, 3, 16);
      begin
        repeat (12) begin @(posedge clk); #1; tready_in = ~tready_in; end
        tready_in = 1'b1;
      end
    join
    drain();

    // next header arrives mid-packet and must not disturb the current one
    push_packet(64'h1111_2222_3333_4444, 5, 3, 5);
    push_packet(64'h5555_6666_7777_8888, 6, 2, 1);
    fork
      begin send_hdr(64'h1111_2222_3333_4444); send_hdr(64'h5555_6666_7777_8888); end
      begin send_lanes(5, 3, 5); send_lanes(6, 2, 1); end
    join
    drain();

    // lane beat waits for a header
    lane_data_in = beat_data(7, 0); lane_valid_in = lane_mask(NL); lane_last_in = 16'h0001;
    repeat (3) begin
      @(negedge clk);
      chk("no_hdr_lane_ready", PS'(lane_ready_out), 0);
    end
    push_packet(64'h0F0E_0D0C_0B0A_0908, 7, 1, 16);
    @(posedge clk); #1;
    hdr_data_in = 64'h0F0E_0D0C_0B0A_0908; hdr_valid_in = 1'b1;
    @(posedge clk); #1;
    hdr_valid_in = 1'b0;
    @(negedge clk);
    chk("hdr_then_lane_ready", PS'(lane_ready_out), 1);
    @(posedge clk); #1;
    lane_valid_in = '0; lane_last_in = '0;
    drain();

    // reset in the middle of a packet
    ignore_out = 1'b1;
    send_hdr(64'h7777_7777_7777_7777);
    drive_beat(beat_data(8, 0), lane_mask(NL), 1'b0);
    lane_data_in = beat_data(8, 1); lane_valid_in = lane_mask(NL);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", PS'(tvalid_out), 0);
    chk("midrst_tkeep", PS'(tkeep_out), 0);
    chk("midrst_tlast", PS'(tlast_out), 0);
    chk("midrst_lane_ready", PS'(lane_ready_out), 0);
    lane_valid_in = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    lane_valid_in = lane_mask(NL); lane_last_in = 16'h0001;
    @(negedge clk);
    chk("postrst_lane_ready", PS'(lane_ready_out), 0);
    chk("postrst_hdr_ready", PS'(hdr_ready_out), 1);
    @(posedge clk); #1;
    lane_valid_in = '0; lane_last_in = '0;
    ignore_out = 1'b0;
    push_packet(64'h9999_AAAA_BBBB_CCCC, 9, 2, 3);
    send_hdr(64'h9999_AAAA_BBBB_CCCC);
    send_lanes(9, 2, 3);
    drain();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
